uart_rx_frame_timer: RTL and testbench

Parametrised oversampling timer for the UART receiver: counts Prescale clock edges per bit and bits per frame, and emits bit-done, frame-done and three-point majority-sample strobes. It sits between the RX FSM, which drives `enable`, and the data sampler and deserializer. Compared with the single-width edge/bit counter, it adds:
- generic widths;
- Prescale and frame length latched at frame start;
- a frame-complete state;
- configuration error detection.

---
 rtl/uart_rx_frame_timer_pkg.sv | 23 ++
 rtl/uart_rx_frame_timer_if.sv | 46 ++++
 rtl/uart_rx_frame_timer_rx_sample_window.sv | 49 ++++
 rtl/uart_rx_frame_timer.sv | 128 ++++++++++++
 tb/tb_uart_rx_frame_timer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_frame_timer_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_timer_pkg
// Shared UART receiver definitions: timer state encoding, the smallest legal
// oversampling ratio and the three majority-sample index codes.
// -----------------------------------------------------------------------------
package uart_rx_frame_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_e;

    // Below this the early/centre/late sample points would not all fit
    // inside one bit period.
    localparam int unsigned PRESCALE_MIN = 4;

    localparam logic [1:0] SAMPLE_EARLY  = 2'd0;
    localparam logic [1:0] SAMPLE_CENTRE = 2'd1;
    localparam logic [1:0] SAMPLE_LATE   = 2'd2;

endpackage

// File: rtl/uart_rx_frame_timer_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_timer_if
// Bundles the frame timer's control inputs and timing outputs.
//   master : RX FSM side    - drives enable/Prescale/frame_bits, observes timing
//   slave  : frame timer    - consumes control, drives timing outputs
// Signals:
//   enable      frame-active request (low aborts)
//   Prescale    clocks per bit, sampled at frame start
//   frame_bits  bits per frame, sampled at frame start
//   edge_cnt    position inside the current bit
//   bit_cnt     completed bits in the current frame
//   bit_done    one-cycle pulse per completed bit
//   frame_done  one-cycle pulse with the final bit_done
//   sample_stb  high on the three majority-sample positions
//   sample_idx  0/1/2 = early/centre/late
//   cfg_err     high while the requested configuration is illegal
// -----------------------------------------------------------------------------
interface uart_rx_frame_timer_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);

    logic                  enable;
    logic [PRESCALE_W-1:0] Prescale;
    logic [BIT_CNT_W-1:0]  frame_bits;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  bit_done;
    logic                  frame_done;
    logic                  sample_stb;
    logic [1:0]            sample_idx;
    logic                  cfg_err;

    modport master (
        output enable, Prescale, frame_bits,
        input  edge_cnt, bit_cnt, bit_done, frame_done,
               sample_stb, sample_idx, cfg_err
    );

    modport slave (
        input  enable, Prescale, frame_bits,
        output edge_cnt, bit_cnt, bit_done, frame_done,
               sample_stb, sample_idx, cfg_err
    );

endinterface

// File: rtl/uart_rx_frame_timer_rx_sample_window.sv
// -----------------------------------------------------------------------------
// rx_sample_window
// Pure combinational decode of the three majority-sample positions around the
// bit centre: edge_cnt == half-1 / half / half+1 -> idx early / centre / late.
// Ports:
//   active      high only while the timer is counting a frame
//   edge_cnt    position inside the current bit
//   half        latched prescale >> 1
//   sample_stb  high on one of the three sample positions
//   sample_idx  which sample position; 0 when sample_stb is low
// -----------------------------------------------------------------------------
module rx_sample_window
    import uart_rx_frame_timer_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  active,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] half,
    output logic                  sample_stb,
    output logic [1:0]            sample_idx
);

    logic [PRESCALE_W-1:0] early_pos;
    logic [PRESCALE_W-1:0] late_pos;

    assign early_pos = half - PRESCALE_W'(1);
    assign late_pos  = half + PRESCALE_W'(1);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise
        // the tool infers a latch to hold the old value.
        sample_stb = 1'b0;
        sample_idx = SAMPLE_EARLY;
        if (active) begin
            if (edge_cnt == early_pos) begin
                sample_stb = 1'b1;
                sample_idx = SAMPLE_EARLY;
            end else if (edge_cnt == half) begin
                sample_stb = 1'b1;
                sample_idx = SAMPLE_CENTRE;
            end else if (edge_cnt == late_pos) begin
                sample_stb = 1'b1;
                sample_idx = SAMPLE_LATE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_timer
// Oversampling timer for the UART receiver. Counts Prescale clock edges per
// bit and bits per frame, pulses bit_done/frame_done, and strobes the three
// majority-sample points of every bit. Prescale and frame_bits are latched on
// the frame start edge; an illegal configuration parks the timer in ERR until
// enable drops.
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-low reset
//   bus  uart_rx_frame_timer_if slave modport (control in, timing out)
// -----------------------------------------------------------------------------
module uart_rx_frame_timer
    import uart_rx_frame_timer_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_rx_frame_timer_if.slave    bus
);

    state_e                state_q;
    logic [PRESCALE_W-1:0] edge_q;
    logic [BIT_CNT_W-1:0]  bit_q;
    logic                  bit_done_q;
    logic                  frame_done_q;
    logic                  cfg_err_q;
    logic [PRESCALE_W-1:0] p_q;
    logic [BIT_CNT_W-1:0]  f_q;

    logic [PRESCALE_W-1:0] last_edge;
    logic [BIT_CNT_W-1:0]  bit_next;
    logic                  cfg_bad;

    assign last_edge = p_q - PRESCALE_W'(1);
    assign bit_next  = bit_q + BIT_CNT_W'(1);
    assign cfg_bad   = (bus.Prescale < PRESCALE_W'(PRESCALE_MIN)) ||
                       (bus.frame_bits == '0);

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: state updates use non-blocking assignments so every register
        // sees the pre-edge value of every other register.
        if (!RST) begin
            state_q      <= IDLE;
            edge_q       <= '0;
            bit_q        <= '0;
            bit_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            p_q          <= '0;
            f_q          <= '0;
        end else if (!bus.enable) begin
            // Abort from any state; the latched config is simply left stale,
            // it is rewritten on the next start.
            state_q      <= IDLE;
            edge_q       <= '0;
            bit_q        <= '0;
            bit_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_bad) begin
                        state_q   <= ERR;
                        cfg_err_q <= 1'b1;
                    end else begin
                        // The start cycle itself is edge 0 of bit 0.
                        p_q     <= bus.Prescale;
                        f_q     <= bus.frame_bits;
                        edge_q  <= PRESCALE_W'(1);
                        bit_q   <= '0;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (edge_q == last_edge) begin
                        edge_q       <= '0;
                        bit_q        <= bit_next;
                        bit_done_q   <= 1'b1;
                        frame_done_q <= (bit_next == f_q);
                        if (bit_next == f_q) begin
                            state_q <= DONE;
                        end
                    end else begin
                        edge_q       <= edge_q + PRESCALE_W'(1);
                        bit_done_q   <= 1'b0;
                        frame_done_q <= 1'b0;
                    end
                end
                DONE: begin
                    // Parked until enable drops; no restart while high.
                    edge_q       <= '0;
                    bit_q        <= f_q;
                    bit_done_q   <= 1'b0;
                    frame_done_q <= 1'b0;
                end
                ERR: begin
                    edge_q    <= '0;
                    bit_q     <= '0;
                    cfg_err_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    rx_sample_window #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sample_window (
        .active     (state_q == COUNT),
        .edge_cnt   (edge_q),
        .half       (p_q >> 1),
        .sample_stb (bus.sample_stb),
        .sample_idx (bus.sample_idx)
    );

    assign bus.edge_cnt   = edge_q;
    assign bus.bit_cnt    = bit_q;
    assign bus.bit_done   = bit_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_timer
// Self-checking bench for uart_rx_frame_timer. The reference model tracks only
// "edges since frame start" plus the latched P/F, and derives every expected
// output from that with division/modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_timer;

    localparam int PW = 6;
    localparam int BW = 4;

    typedef struct packed {
        logic [PW-1:0] edge_cnt;
        logic [BW-1:0] bit_cnt;
        logic          bit_done;
        logic          frame_done;
        logic          sample_stb;
        logic [1:0]    sample_idx;
        logic          cfg_err;
    } obs_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_rx_frame_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

    uart_rx_frame_timer #(
        .PRESCALE_W (PW),
        .BIT_CNT_W  (BW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = running a frame, 2 = config error.
    int m_mode = 0;
    int m_p    = 0;
    int m_f    = 0;
    int m_t    = 0;   // edges since the start edge (start edge is t = 0)

    task automatic model_edge();
        if (!RST || !bus.enable) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (int'(bus.Prescale) < 4 || bus.frame_bits == 0) begin
                        m_mode = 2;
                    end else begin
                        m_p    = int'(bus.Prescale);
                        m_f    = int'(bus.frame_bits);
                        m_t    = 0;
                        m_mode = 1;
                    end
                end
                1: if (m_t < m_p * m_f) m_t++;
                default: ;
            endcase
        end
    endtask

    function automatic obs_t expected();
        obs_t e;
        int   pos;
        int   h;
        e = '0;
        if (m_mode == 2) begin
            e.cfg_err = 1'b1;
        end else if (m_mode == 1) begin
            if (m_t >= m_p * m_f - 1) begin
                e.bit_cnt    = BW'(m_f);
                e.bit_done   = (m_t == m_p * m_f - 1);
                e.frame_done = e.bit_done;
            end else begin
                pos        = m_t + 1;
                e.edge_cnt = PW'(pos % m_p);
                e.bit_cnt  = BW'(pos / m_p);
                e.bit_done = (pos % m_p == 0);
                h = m_p / 2;
                if (pos % m_p >= h - 1 && pos % m_p <= h + 1) begin
                    e.sample_stb = 1'b1;
                    e.sample_idx = 2'(pos % m_p - (h - 1));
                end
            end
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.edge_cnt   = bus.edge_cnt;
        o.bit_cnt    = bus.bit_cnt;
        o.bit_done   = bus.bit_done;
        o.frame_done = bus.frame_done;
        o.sample_stb = bus.sample_stb;
        o.sample_idx = bus.sample_idx;
        o.cfg_err    = bus.cfg_err;
        return o;
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        bus.enable     = 1'b1;
        bus.Prescale   = 6'd8;
        bus.frame_bits = 4'd10;
        #2;
        got = observed();
        checks++;
        if (got !== obs_t'(0))
            $display("FAIL reset_state got=%h exp=%h", got, obs_t'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            got = observed();
            checks++;
            if (got !== expected()) begin
                errors++;
                $display("FAIL reset_hold c=%0d got=%h exp=%h", c, got, expected());
            end
        end
        if (got !== obs_t'(0)) errors += 0;
        bus.enable = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        obs_t got;
        int   nbd   = 0;
        int   nfd   = 0;
        int   fd_at = -1;
        bus.Prescale   = 6'd8;
        bus.frame_bits = 4'd10;
        bus.enable     = 1'b1;
        for (int c = 0; c < 95; c++) begin
            tick();
            got = observed();
            checks++;
            if (got !== expected()) begin
                errors++;
                $display("FAIL full_frame c=%0d got=%h exp=%h", c, got, expected());
            end
            if (got.bit_done)   nbd++;
            if (got.frame_done) begin nfd++; fd_at = c; end
        end
        checks++;
        if (nbd != 10) begin errors++; $display("FAIL full_frame_bit_done_count got=%0d exp=10", nbd); end
        checks++;
        if (nfd != 1 || fd_at != 79) begin
            errors++;
            $display("FAIL full_frame_done_edge count=%0d at=%0d exp count=1 at=79", nfd, fd_at);
        end
        checks++;
        if (got.bit_cnt !== 4'd10 || got.edge_cnt !== 6'd0) begin
            errors++;
            $display("FAIL full_frame_done_hold bit_cnt=%0d edge_cnt=%0d exp 10/0", got.bit_cnt, got.edge_cnt);
        end
        bus.enable = 1'b0;
        tick();
        got = observed();
        checks++;
        if (got !== expected()) begin
            errors++;
            $display("FAIL full_frame_release got=%h exp=%h", got, expected());
        end
    endtask

    task automatic test_sample_points();
        obs_t got;
        int   p_list [3];
        int   nstb;
        int   f;
        p_list[0] = 8;
        p_list[1] = 5;
        p_list[2] = int'($urandom_range(4, 40));
        for (int k = 0; k < 3; k++) begin
            f              = int'($urandom_range(1, 4));
            nstb           = 0;
            bus.Prescale   = PW'(p_list[k]);
            bus.frame_bits = BW'(f);
            bus.enable     = 1'b1;
            for (int c = 0; c < p_list[k] * f + 2; c++) begin
                tick();
                got = observed();
                checks++;
                if (got !== expected()) begin
                    errors++;
                    $display("FAIL sample_points p=%0d c=%0d got=%h exp=%h", p_list[k], c, got, expected());
                end
                if (got.sample_stb) nstb++;
            end
            checks++;
            if (nstb != 3 * f) begin
                errors++;
                $display("FAIL sample_points_count p=%0d got=%0d exp=%0d", p_list[k], nstb, 3 * f);
            end
            bus.enable = 1'b0;
            tick();
        end
    endtask

    task automatic test_cfg_change();
        obs_t got;
        int   fd_at = -1;
        bus.Prescale   = 6'd16;
        bus.frame_bits = 4'd11;
        bus.enable     = 1'b1;
        for (int c = 0; c < 180; c++) begin
            if (c == 48) begin
                bus.Prescale   = 6'd8;
                bus.frame_bits = 4'd3;
            end
            tick();
            got = observed();
            checks++;
            if (got !== expected()) begin
                errors++;
                $display("FAIL cfg_change c=%0d got=%h exp=%h", c, got, expected());
            end
            if (got.frame_done) fd_at = c;
        end
        checks++;
        if (fd_at != 175) begin
            errors++;
            $display("FAIL cfg_change_frame_done at=%0d exp=175", fd_at);
        end
        bus.enable = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        obs_t got;
        int   nfd = 0;
        bus.Prescale   = 6'd8;
        bus.frame_bits = 4'd10;
        bus.enable     = 1'b1;
        for (int c = 0; c <= 37; c++) begin
            tick();
            got = observed();
            checks++;
            if (got !== expected()) begin
                errors++;
                $display("FAIL abort_run c=%0d got=%h exp=%h", c, got, expected());
            end
        end
        checks++;
        if (got.bit_cnt !== 4'd4 || got.edge_cnt !== 6'd6) begin
            errors++;
            $display("FAIL abort_point bit_cnt=%0d edge_cnt=%0d exp 4/6", got.bit_cnt, got.edge_cnt);
        end
        bus.enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            got = observed();
            if (got.frame_done) nfd++;
            checks++;
            if (got !== obs_t'(0)) begin
                errors++;
                $display("FAIL abort_clear c=%0d got=%h exp=%h", c, got, obs_t'(0));
            end
        end
        bus.enable = 1'b1;
        tick();
        got = observed();
        checks++;
        if (got.edge_cnt !== 6'd1 || got.bit_cnt !== 4'd0 || nfd != 0) begin
            errors++;
            $display("FAIL abort_rearm edge_cnt=%0d bit_cnt=%0d frame_done_seen=%0d exp 1/0/0",
                     got.edge_cnt, got.bit_cnt, nfd);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            got = observed();
            checks++;
            if (got !== expected()) begin
                errors++;
                $display("FAIL abort_rerun c=%0d got=%h exp=%h", c, got, expected());
            end
        end
        bus.enable = 1'b0;
        tick();
    endtask

    task automatic test_cfg_err();
        obs_t got;
        int   pv [3];
        int   fv [3];
        int   nbd;
        pv[0] = 3;  fv[0] = 10;
        pv[1] = 8;  fv[1] = 0;
        pv[2] = int'($urandom_range(0, 3)); fv[2] = int'($urandom_range(1, 15));
        for (int k = 0; k < 3; k++) begin
            nbd            = 0;
            bus.Prescale   = PW'(pv[k]);
            bus.frame_bits = BW'(fv[k]);
            bus.enable     = 1'b1;
            for (int c = 0; c < 6; c++) begin
                tick();
                got = observed();
                if (got.bit_done) nbd++;
                checks++;
                if (got !== expected()) begin
                    errors++;
                    $display("FAIL cfg_err_run p=%0d f=%0d c=%0d got=%h exp=%h", pv[k], fv[k], c, got, expected());
                end
            end
            checks++;
            if (got.cfg_err !== 1'b1 || nbd != 0) begin
                errors++;
                $display("FAIL cfg_err_level p=%0d f=%0d cfg_err=%b bit_done_seen=%0d exp 1/0", pv[k], fv[k], got.cfg_err, nbd);
            end
            bus.enable = 1'b0;
            tick();
            got = observed();
            checks++;
            if (got.cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_clear p=%0d got=%b exp=0", pv[k], got.cfg_err);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        bus.Prescale   = 6'd8;
        bus.frame_bits = 4'd10;
        bus.enable     = 1'b1;
        for (int c = 0; c < 42; c++) tick();
        got = observed();
        checks++;
        if (got.bit_cnt !== 4'd5) begin
            errors++;
            $display("FAIL async_reset_setup bit_cnt=%0d exp=5", got.bit_cnt);
        end
        #3;
        RST    = 1'b0;
        m_mode = 0;
        #1;
        got = observed();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL async_reset_clear got=%h exp=%h", got, obs_t'(0));
        end
        RST = 1'b1;
        tick();
        got = observed();
        checks++;
        if (got.edge_cnt !== 6'd1 || got.bit_cnt !== 4'd0 || got !== expected()) begin
            errors++;
            $display("FAIL async_reset_restart got=%h exp=%h", got, expected());
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            got = observed();
            checks++;
            if (got !== expected()) begin
                errors++;
                $display("FAIL async_reset_rerun c=%0d got=%h exp=%h", c, got, expected());
            end
        end
        bus.enable = 1'b0;
        tick();
    endtask

    task automatic test_random();
        obs_t got;
        int   p;
        int   f;
        int   len;
        for (int fr = 0; fr < 14; fr++) begin
            p   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 20));
            f   = int'($urandom_range(0, 15));
            len = int'($urandom_range(1, p * f + 6));
            bus.Prescale   = PW'(p);
            bus.frame_bits = BW'(f);
            bus.enable     = 1'b1;
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 30) == 0) begin
                    bus.Prescale   = PW'($urandom());
                    bus.frame_bits = BW'($urandom());
                end
                tick();
                got = observed();
                checks++;
                if (got !== expected()) begin
                    errors++;
                    $display("FAIL random fr=%0d c=%0d got=%h exp=%h", fr, c, got, expected());
                end
            end
            bus.enable = 1'b0;
            for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
                tick();
                got = observed();
                checks++;
                if (got !== expected()) begin
                    errors++;
                    $display("FAIL random_gap fr=%0d got=%h exp=%h", fr, got, expected());
                end
            end
        end
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.Prescale   = '0;
        bus.frame_bits = '0;
        test_reset();
        test_full_frame();
        test_sample_points();
        test_cfg_change();
        test_abort();
        test_cfg_err();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
